// File: rtl/unidade_controle_sinfonia.sv
// unidade_controle_sinfonia
// Moore control unit for the "sinfonia" memory game. It scrolls the intro
// phrase, latches the chosen song, plays each round's notes through the
// Arduino, then collects and compares player presses, counts errors and
// updates the score. Every datapath control is decoded from the current
// state only.
//
// Ports
//   clock, reset            : system clock, asynchronous active-low reset
//   iniciar                 : start/restart request (level)
//   botoesIgualMemoria .. timeout_contador_msg : datapath condition flags
//   zera_*                  : datapath clears
//   enable_*                : datapath enables
//   activate_arduino, calcular_pontos, select_mux_arduino, select_mux_letra
//                           : datapath steering
//   contagem_display        : free-running display digit index
//   pronto, ganhou, perdeu  : game status
//   db_estado               : current state code
module unidade_controle_sinfonia #(
  parameter int MSG_STEPS = 21,
  parameter int MAX_ERROS = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       botoesIgualMemoria,
  input  logic       enderecoIgualLimite,
  input  logic       fimL,
  input  logic       tem_botao_pressionado,
  input  logic       tem_jogada,
  input  logic       timeout_contador_buzzer,
  input  logic       timeout_contador_msg,
  output logic       zera_contador_erro,
  output logic       zera_contador_jogada,
  output logic       zera_contador_msg,
  output logic       zera_contador_rodada,
  output logic       zera_registrador_botoes,
  output logic       zera_registrador_pontos,
  output logic       zera_timer_buzzer,
  output logic       zera_timer_msg,
  output logic       enable_contador_erro,
  output logic       enable_contador_jogada,
  output logic       enable_contador_msg,
  output logic       enable_contador_rodada,
  output logic       enable_registrador_botoes,
  output logic       enable_registrador_musica,
  output logic       enable_registrador_pontos,
  output logic       enable_timer_buzzer,
  output logic       enable_timer_msg,
  output logic       activate_arduino,
  output logic       calcular_pontos,
  output logic       select_mux_arduino,
  output logic       select_mux_letra,
  output logic [1:0] contagem_display,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic [4:0] db_estado
);

  localparam logic [4:0] INICIAL        = 5'd0;
  localparam logic [4:0] MSG_TIMER      = 5'd1;
  localparam logic [4:0] MSG_AVANCA     = 5'd2;
  localparam logic [4:0] ESPERA_MUSICA  = 5'd3;
  localparam logic [4:0] REG_MUSICA     = 5'd4;
  localparam logic [4:0] PREPARA_RODADA = 5'd5;
  localparam logic [4:0] TOCA_NOTA      = 5'd6;
  localparam logic [4:0] AVANCA_NOTA    = 5'd7;
  localparam logic [4:0] ZERA_JOGADA    = 5'd8;
  localparam logic [4:0] ESPERA_JOGADA  = 5'd9;
  localparam logic [4:0] REGISTRA       = 5'd10;
  localparam logic [4:0] COMPARA        = 5'd11;
  localparam logic [4:0] PROXIMA_JOGADA = 5'd12;
  localparam logic [4:0] ERRO           = 5'd13;
  localparam logic [4:0] FIM_RODADA     = 5'd14;
  localparam logic [4:0] PROXIMA_RODADA = 5'd15;
  localparam logic [4:0] FIM_JOGO       = 5'd16;

  localparam int MW = $clog2(MSG_STEPS + 1);

  logic [4:0]    estado, estado_next;
  logic [MW-1:0] cnt_msg;
  logic [3:0]    cnt_erro;
  logic          ultimo_msg, ultimo_erro;

  assign ultimo_msg  = (cnt_msg == MW'(MSG_STEPS - 1));
  assign ultimo_erro = ((cnt_erro + 4'd1) == 4'(MAX_ERROS));

  // Press-detect flag is not needed by this sequencing; tem_jogada is the
  // debounced event actually acted upon.
  logic unused_ok;
  assign unused_ok = tem_botao_pressionado;

  always_comb begin
    estado_next = INICIAL;
    case (estado)
      INICIAL:        estado_next = iniciar ? MSG_TIMER : INICIAL;
      MSG_TIMER:      estado_next = timeout_contador_msg ? MSG_AVANCA : MSG_TIMER;
      MSG_AVANCA:     estado_next = ultimo_msg ? ESPERA_MUSICA : MSG_TIMER;
      ESPERA_MUSICA:  estado_next = tem_jogada ? REG_MUSICA : ESPERA_MUSICA;
      REG_MUSICA:     estado_next = PREPARA_RODADA;
      PREPARA_RODADA: estado_next = TOCA_NOTA;
      TOCA_NOTA:
        if (timeout_contador_buzzer)
          estado_next = enderecoIgualLimite ? ZERA_JOGADA : AVANCA_NOTA;
        else
          estado_next = TOCA_NOTA;
      AVANCA_NOTA:    estado_next = TOCA_NOTA;
      ZERA_JOGADA:    estado_next = ESPERA_JOGADA;
      ESPERA_JOGADA:  estado_next = tem_jogada ? REGISTRA : ESPERA_JOGADA;
      REGISTRA:       estado_next = COMPARA;
      COMPARA:
        if (botoesIgualMemoria)
          estado_next = enderecoIgualLimite ? FIM_RODADA : PROXIMA_JOGADA;
        else
          estado_next = ERRO;
      PROXIMA_JOGADA: estado_next = ESPERA_JOGADA;
      ERRO:           estado_next = ultimo_erro ? FIM_JOGO : ESPERA_JOGADA;
      FIM_RODADA:     estado_next = fimL ? FIM_JOGO : PROXIMA_RODADA;
      PROXIMA_RODADA: estado_next = PREPARA_RODADA;
      FIM_JOGO:       estado_next = iniciar ? INICIAL : FIM_JOGO;
      default:        estado_next = INICIAL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado           <= INICIAL;
      cnt_msg          <= '0;
      cnt_erro         <= '0;
      contagem_display <= '0;
      ganhou           <= 1'b0;
      perdeu           <= 1'b0;
    end else begin
      estado           <= estado_next;
      contagem_display <= contagem_display + 2'd1;
      case (estado)
        INICIAL: begin
          cnt_msg  <= '0;
          cnt_erro <= '0;
          ganhou   <= 1'b0;
          perdeu   <= 1'b0;
        end
        MSG_AVANCA: cnt_msg <= cnt_msg + MW'(1);
        ERRO: begin
          cnt_erro <= cnt_erro + 4'd1;
          if (ultimo_erro) perdeu <= 1'b1;
        end
        FIM_RODADA: if (fimL) ganhou <= 1'b1;
        PROXIMA_RODADA: cnt_erro <= '0;
        // Status is also dropped on the way out so INICIAL already shows 0.
        FIM_JOGO: if (iniciar) begin
          ganhou <= 1'b0;
          perdeu <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    zera_contador_erro        = 1'b0;
    zera_contador_jogada      = 1'b0;
    zera_contador_msg         = 1'b0;
    zera_contador_rodada      = 1'b0;
    zera_registrador_botoes   = 1'b0;
    zera_registrador_pontos   = 1'b0;
    zera_timer_buzzer         = 1'b0;
    zera_timer_msg            = 1'b0;
    enable_contador_erro      = 1'b0;
    enable_contador_jogada    = 1'b0;
    enable_contador_msg       = 1'b0;
    enable_contador_rodada    = 1'b0;
    enable_registrador_botoes = 1'b0;
    enable_registrador_musica = 1'b0;
    enable_registrador_pontos = 1'b0;
    enable_timer_buzzer       = 1'b0;
    enable_timer_msg          = 1'b0;
    activate_arduino          = 1'b0;
    calcular_pontos           = 1'b0;
    select_mux_arduino        = 1'b0;
    select_mux_letra          = 1'b0;
    pronto                    = 1'b0;
    case (estado)
      INICIAL: begin
        zera_contador_erro      = 1'b1;
        zera_contador_jogada    = 1'b1;
        zera_contador_msg       = 1'b1;
        zera_contador_rodada    = 1'b1;
        zera_registrador_botoes = 1'b1;
        zera_registrador_pontos = 1'b1;
        zera_timer_buzzer       = 1'b1;
        zera_timer_msg          = 1'b1;
      end
      MSG_TIMER: enable_timer_msg = 1'b1;
      MSG_AVANCA: begin
        enable_contador_msg = 1'b1;
        zera_timer_msg      = 1'b1;
      end
      REG_MUSICA: enable_registrador_musica = 1'b1;
      PREPARA_RODADA: begin
        zera_contador_jogada = 1'b1;
        zera_timer_buzzer    = 1'b1;
      end
      TOCA_NOTA: begin
        select_mux_arduino  = 1'b1;
        activate_arduino    = 1'b1;
        enable_timer_buzzer = 1'b1;
        select_mux_letra    = 1'b1;
      end
      AVANCA_NOTA: begin
        enable_contador_jogada = 1'b1;
        zera_timer_buzzer      = 1'b1;
      end
      ZERA_JOGADA: begin
        zera_contador_jogada    = 1'b1;
        zera_registrador_botoes = 1'b1;
      end
      ESPERA_JOGADA: begin
        activate_arduino = 1'b1;
        select_mux_letra = 1'b1;
      end
      REGISTRA:       enable_registrador_botoes = 1'b1;
      PROXIMA_JOGADA: enable_contador_jogada = 1'b1;
      ERRO:           enable_contador_erro = 1'b1;
      FIM_RODADA: begin
        calcular_pontos           = 1'b1;
        enable_registrador_pontos = 1'b1;
      end
      PROXIMA_RODADA: begin
        enable_contador_rodada = 1'b1;
        zera_contador_erro     = 1'b1;
      end
      FIM_JOGO: pronto = 1'b1;
      default: ;
    endcase
  end

  assign db_estado = estado;

endmodule
